// File: rtl/dff_sr.sv
// Purpose: 1-bit D flip-flop with synchronous active-high reset.
// Latency: q follows d one clk rising edge later.
// Backpressure: none; captures d on every edge.
module dff_sr (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    // Capture d each rising edge; reset only takes effect at an edge, never between edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 1'b0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/circuit2.sv
// Purpose: registered gate network E = (R & L) & ~(I & M).
// Latency: one clk cycle from sampled inputs to E.
// Backpressure: none; a new vector is accepted every cycle.
module circuit2 (
    input  logic clk,
    input  logic rst,
    input  logic I,
    input  logic M,
    input  logic R,
    input  logic L,
    output logic E
);

    logic rl_and;
    logic im_nand;
    logic f;

    // Primitive gates keep X/Z propagation true to gate semantics in simulation.
    and  g_rl  (rl_and,  R, L);
    nand g_im  (im_nand, I, M);
    and  g_out (f, rl_and, im_nand);

    // The only state element; registering F keeps E glitch-free between edges.
    dff_sr u_e_reg (
        .clk (clk),
        .rst (rst),
        .d   (f),
        .q   (E)
    );

endmodule

// File: tb/tb_circuit2.sv
// Purpose: self-checking bench for circuit2 using an expected-value queue.
// Latency: each driven vector is checked one rising edge after it is applied.
// Backpressure: not applicable.
module tb_circuit2;

    logic clk;
    logic rst;
    logic I;
    logic M;
    logic R;
    logic L;
    logic E;

    typedef struct {
        string tag;
        logic  exp;
    } sb_entry_t;

    sb_entry_t sb_q[$];
    int compared;
    int mismatched;

    circuit2 dut (
        .clk (clk),
        .rst (rst),
        .I   (I),
        .M   (M),
        .R   (R),
        .L   (L),
        .E   (E)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference truth table: F is 1 only for IMRL = 0011, 0111, 1011.
    function automatic logic ref_f(input logic [3:0] v);
        return (v == 4'b0011) || (v == 4'b0111) || (v == 4'b1011);
    endfunction

    // Compare E against a required value right now.
    task automatic check(input string tag, input logic exp);
        compared++;
        assert (E === exp) else begin
            mismatched++;
            $error("FAIL %s: observed E=%b expected E=%b", tag, E, exp);
        end
    endtask

    // Pop the oldest expectation and compare it against E.
    task automatic check_pop();
        sb_entry_t ent;
        if (sb_q.size() == 0) begin
            compared++;
            mismatched++;
            $error("FAIL scoreboard_empty: observed no entry expected one entry");
        end else begin
            ent = sb_q.pop_front();
            check(ent.tag, ent.exp);
        end
    endtask

    // Drive one vector at the falling edge, record its expectation, check after the next rising edge.
    task automatic drive(input logic r, input logic [3:0] v, input string tag);
        sb_entry_t ent;
        @(negedge clk);
        rst = r;
        {I, M, R, L} = v;
        ent.tag = tag;
        ent.exp = r ? 1'b0 : ref_f(v);
        sb_q.push_back(ent);
        @(posedge clk);
        #1;
        check_pop();
    endtask

    initial begin
        logic [3:0] therm [5];
        sb_entry_t  ent;
        compared   = 0;
        mismatched = 0;
        rst = 1'b1;
        {I, M, R, L} = 4'b1111;

        // Reset held for two cycles with all inputs high.
        drive(1'b1, 4'b1111, "reset_cycle0");
        drive(1'b1, 4'b1111, "reset_cycle1");

        // Thermometer sweep.
        therm[0] = 4'b0000;
        therm[1] = 4'b0001;
        therm[2] = 4'b0011;
        therm[3] = 4'b0111;
        therm[4] = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, therm[i], $sformatf("therm_%b", therm[i]));
        end

        // Exhaustive truth table.
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 4'(i), $sformatf("tt_%b", 4'(i)));
        end

        // Latency: change between edges; E must hold until the next edge.
        drive(1'b0, 4'b0000, "lat_base");
        @(negedge clk);
        {I, M, R, L} = 4'b0011;
        #2;
        check("lat_hold_midcycle", 1'b0);
        ent.tag = "lat_after_edge";
        ent.exp = 1'b1;
        sb_q.push_back(ent);
        @(posedge clk);
        #1;
        check_pop();

        // Reset mid-operation; rst rising between edges must not move E.
        drive(1'b0, 4'b0011, "mid_pre_rst");
        @(negedge clk);
        rst = 1'b1;
        #2;
        check("mid_rst_async_hold", 1'b1);
        ent.tag = "mid_rst_edge";
        ent.exp = 1'b0;
        sb_q.push_back(ent);
        @(posedge clk);
        #1;
        check_pop();
        @(negedge clk);
        rst = 1'b0;
        #2;
        check("mid_rst_release_hold", 1'b0);
        ent.tag = "mid_post_rst";
        ent.exp = 1'b1;
        sb_q.push_back(ent);
        @(posedge clk);
        #1;
        check_pop();

        // Nothing should remain outstanding.
        compared++;
        assert (sb_q.size() == 0) else begin
            mismatched++;
            $error("FAIL scoreboard_drain: observed %0d entries expected 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
